// File: rtl/mem_responder_if.sv
// Core memory pins: fetch port, load/store port and their level-protocol responses.
// master = core side, slave = mem_responder.
interface mem_responder_if;
  logic [55:0] instruction_address;
  logic        input_instruction_request;
  logic [31:0] input_instruction;
  logic        input_instruction_valid;
  logic [55:0] data_address;
  logic [1:0]  data_size;
  logic        input_data_request;
  logic        input_data_unsigned;
  logic [63:0] input_data;
  logic        input_data_valid;
  logic        output_data_request;
  logic [63:0] output_data;
  logic        output_data_complete;

  modport master (
    output instruction_address, input_instruction_request,
    output data_address, data_size, input_data_request, input_data_unsigned,
    output output_data_request, output_data,
    input  input_instruction, input_instruction_valid,
    input  input_data, input_data_valid, output_data_complete
  );

  modport slave (
    input  instruction_address, input_instruction_request,
    input  data_address, data_size, input_data_request, input_data_unsigned,
    input  output_data_request, output_data,
    output input_instruction, input_instruction_valid,
    output input_data, input_data_valid, output_data_complete
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: fetch and load/store ports served from one
// single-ported doubleword RAM with programmable wait states.
module mem_responder #(
  parameter int MEM_WORDS   = 8192,
  parameter int WAIT_STATES = 0
) (
  input logic             phi1,
  input logic             rst,
  mem_responder_if.slave  bus
);
  // state  | meaning
  // IDLE   | nothing in flight; arbitrate, data before fetch
  // BUSY_I | fetch captured, counting down wait states
  // BUSY_D | load/store captured, counting down wait states
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef struct packed {
    logic        store;
    logic [55:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] data;
  } dtag_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [53:0] i_tag_q, i_cur;
  dtag_t       d_tag_q, d_cur;
  logic        i_served, d_served;
  logic [31:0] instr_q;
  logic [63:0] ldata_q;
  logic [63:0] ram [MEM_WORDS];

  logic [63:0] size_mask;
  logic        i_req, d_req, i_match, d_match, i_hit, d_hit, i_pend, d_pend;
  logic        cap_i, cap_d, done_i, done_d;
  logic [52:0] d_dw, i_dw;
  logic [2:0]  d_off;
  logic        d_in_range, i_in_range, d_mis;
  logic [AW-1:0] rd_idx;
  logic [63:0] rd_dw, shifted, load_val, wr_sh, ram_wdata;
  logic [7:0]  be_base, be;
  logic        ram_we;
  logic [31:0] fetch_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.instruction_address[1:0];

  always_comb begin
    size_mask = 64'hffff_ffff_ffff_ffff;
    case (bus.data_size)
      2'd0:    size_mask = 64'h0000_0000_0000_00ff;
      2'd1:    size_mask = 64'h0000_0000_0000_ffff;
      2'd2:    size_mask = 64'h0000_0000_ffff_ffff;
      default: size_mask = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  // A load's tag ignores store data; a store's tag ignores the extension mode.
  always_comb begin
    d_cur       = '0;
    d_cur.store = bus.output_data_request;
    d_cur.addr  = bus.data_address;
    d_cur.size  = bus.data_size;
    if (bus.output_data_request) d_cur.data = bus.output_data & size_mask;
    else                         d_cur.uns  = bus.input_data_unsigned;
  end

  assign i_cur   = bus.instruction_address[55:2];
  assign i_req   = bus.input_instruction_request;
  assign d_req   = bus.input_data_request | bus.output_data_request;
  assign i_match = i_req && (i_cur == i_tag_q);
  assign d_match = d_req && (d_cur == d_tag_q);
  assign i_hit   = i_served && i_match;
  assign d_hit   = d_served && d_match;
  assign i_pend  = i_req && !i_hit;
  assign d_pend  = d_req && !d_hit;

  assign bus.input_instruction_valid = i_hit;
  assign bus.input_data_valid        = d_hit && bus.input_data_request;
  assign bus.output_data_complete    = d_hit && bus.output_data_request;
  assign bus.input_instruction       = instr_q;
  assign bus.input_data              = ldata_q;

  assign d_dw       = d_tag_q.addr[55:3];
  assign d_off      = d_tag_q.addr[2:0];
  assign i_dw       = i_tag_q[53:1];
  assign d_in_range = d_dw < 53'(MEM_WORDS);
  assign i_in_range = i_dw < 53'(MEM_WORDS);
  assign d_mis      = |(d_off & ((3'd1 << d_tag_q.size) - 3'd1));
  assign rd_idx     = (state == BUSY_I) ? i_dw[AW-1:0] : d_dw[AW-1:0];
  assign rd_dw      = ram[rd_idx];
  assign shifted    = rd_dw >> {d_off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (d_tag_q.size)
      2'd0: load_val = d_tag_q.uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_val = d_tag_q.uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_val = d_tag_q.uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
    if (!d_in_range || d_mis) load_val = '0;
  end

  // For a double, 1<<8 wraps to 0 in 8 bits, so the subtraction yields 8'hff.
  assign be_base = (8'd1 << (4'd1 << d_tag_q.size)) - 8'd1;
  assign be      = be_base << d_off;
  assign wr_sh   = d_tag_q.data << {d_off, 3'b000};

  always_comb begin
    ram_wdata = rd_dw;
    for (int b = 0; b < 8; b++)
      if (be[b]) ram_wdata[b*8 +: 8] = wr_sh[b*8 +: 8];
  end

  assign ram_we     = done_d && !rst && d_tag_q.store && d_in_range && !d_mis;
  assign fetch_word = !i_in_range ? 32'h0000_0013 : (i_tag_q[0] ? rd_dw[63:32] : rd_dw[31:0]);

  // Completion re-arbitrates toward the other port so a waiting fetch
  // starts on the same edge the data access finishes.
  always_comb begin
    state_nx = state;
    cap_i    = 1'b0;
    cap_d    = 1'b0;
    done_i   = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend) begin
          cap_d    = 1'b1;
          state_nx = BUSY_D;
        end else if (i_pend) begin
          cap_i    = 1'b1;
          state_nx = BUSY_I;
        end
      end
      BUSY_D: begin
        if (!d_match) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          done_d = 1'b1;
          if (i_pend) begin
            cap_i    = 1'b1;
            state_nx = BUSY_I;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      BUSY_I: begin
        if (!i_match) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          done_i = 1'b1;
          if (d_pend) begin
            cap_d    = 1'b1;
            state_nx = BUSY_D;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      i_tag_q  <= '0;
      d_tag_q  <= '0;
      i_served <= 1'b0;
      d_served <= 1'b0;
      instr_q  <= '0;
      ldata_q  <= '0;
    end else begin
      state <= state_nx;
      if (cap_i || cap_d)    cnt <= 4'(WAIT_STATES);
      else if (cnt != 4'd0)  cnt <= cnt - 4'd1;
      if (cap_i) i_tag_q <= i_cur;
      if (cap_d) d_tag_q <= d_cur;
      i_served <= done_i || (i_served && i_match);
      d_served <= done_d || (d_served && d_match);
      if (done_i) instr_q <= fetch_word;
      if (done_d && !d_tag_q.store) ldata_q <= load_val;
    end
  end

  always_ff @(posedge phi1) begin
    if (ram_we) ram[rd_idx] <= ram_wdata;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (W=0, W=2, W=3) with a
// scoreboard queue of expected load/fetch results.
module tb_mem_responder;
  localparam int MW = 64;

  logic phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  logic rst0, rst2, rst3;
  mem_responder_if bus0();
  mem_responder_if bus2();
  mem_responder_if bus3();

  mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (.phi1(phi1), .rst(rst0), .bus(bus0.slave));
  mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(2)) dut2 (.phi1(phi1), .rst(rst2), .bus(bus2.slave));
  mem_responder #(.MEM_WORDS(MW), .WAIT_STATES(3)) dut3 (.phi1(phi1), .rst(rst3), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge phi1);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic store0(input logic [55:0] a, input logic [1:0] sz, input logic [63:0] d,
                        input int hold, input int exp_writes, input string tag);
    int k, nw;
    bus0.data_address = a;
    bus0.data_size = sz;
    bus0.output_data = d;
    bus0.output_data_request = 1'b1;
    k = 0;
    nw = 0;
    while (!bus0.output_data_complete && k < 20) begin
      if (dut0.ram_we) nw++;
      tick(1);
      k++;
    end
    check({tag, "_complete"}, 64'(bus0.output_data_complete), 64'd1);
    repeat (hold) begin
      if (dut0.ram_we) nw++;
      tick(1);
    end
    check({tag, "_held"}, 64'(bus0.output_data_complete), 64'd1);
    check({tag, "_writes"}, 64'(nw), 64'(exp_writes));
    bus0.output_data_request = 1'b0;
    tick(1);
  endtask

  task automatic load0(input logic [55:0] a, input logic [1:0] sz, input logic uns,
                       input logic [63:0] exp_v, input string tag);
    int k;
    logic [63:0] e;
    exp_q.push_back(exp_v);
    bus0.data_address = a;
    bus0.data_size = sz;
    bus0.input_data_unsigned = uns;
    bus0.input_data_request = 1'b1;
    k = 0;
    while (!bus0.input_data_valid && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_valid"}, 64'(bus0.input_data_valid), 64'd1);
    e = exp_q.pop_front();
    check(tag, bus0.input_data, e);
    bus0.input_data_request = 1'b0;
    tick(1);
  endtask

  task automatic fetch0(input logic [55:0] a, input logic [31:0] exp_v, input string tag);
    int k;
    logic [63:0] e;
    exp_q.push_back({32'd0, exp_v});
    bus0.instruction_address = a;
    bus0.input_instruction_request = 1'b1;
    k = 0;
    while (!bus0.input_instruction_valid && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_valid"}, 64'(bus0.input_instruction_valid), 64'd1);
    e = exp_q.pop_front();
    check(tag, {32'd0, bus0.input_instruction}, e);
    bus0.input_instruction_request = 1'b0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nw, first_d, first_i, bad3;
    logic [63:0] e;
    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    bus0.instruction_address = '0; bus0.input_instruction_request = 1'b0;
    bus0.data_address = '0; bus0.data_size = '0; bus0.input_data_request = 1'b0;
    bus0.input_data_unsigned = 1'b0; bus0.output_data_request = 1'b0; bus0.output_data = '0;
    bus2.instruction_address = '0; bus2.input_instruction_request = 1'b0;
    bus2.data_address = '0; bus2.data_size = '0; bus2.input_data_request = 1'b0;
    bus2.input_data_unsigned = 1'b0; bus2.output_data_request = 1'b0; bus2.output_data = '0;
    bus3.instruction_address = '0; bus3.input_instruction_request = 1'b0;
    bus3.data_address = '0; bus3.data_size = '0; bus3.input_data_request = 1'b0;
    bus3.input_data_unsigned = 1'b0; bus3.output_data_request = 1'b0; bus3.output_data = '0;
    tick(3);

    check("rst_ivalid", 64'(bus0.input_instruction_valid), 64'd0);
    check("rst_dvalid", 64'(bus0.input_data_valid), 64'd0);
    check("rst_complete", 64'(bus0.output_data_complete), 64'd0);
    check("rst_instr", {32'd0, bus0.input_instruction}, 64'd0);
    check("rst_data", bus0.input_data, 64'd0);
    rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    tick(1);

    // preload doubleword 0, then fetch with exact W=0 latency
    store0(56'h0, 2'd3, 64'h0000_0093_0000_0013, 0, 1, "preload0");
    exp_q.push_back(64'h13);
    bus0.instruction_address = 56'h0;
    bus0.input_instruction_request = 1'b1;
    tick(1);
    check("fetch0_not_yet", 64'(bus0.input_instruction_valid), 64'd0);
    tick(1);
    check("fetch0_valid", 64'(bus0.input_instruction_valid), 64'd1);
    e = exp_q.pop_front();
    check("fetch0_data", {32'd0, bus0.input_instruction}, e);
    bus0.instruction_address = 56'h4;
    #1;
    check("fetch_retag_drop", 64'(bus0.input_instruction_valid), 64'd0);
    bus0.input_instruction_request = 1'b0;
    tick(1);
    fetch0(56'h4, 32'h0000_0093, "fetch4");

    // byte-lane merge and extension
    store0(56'h10, 2'd3, 64'h0706_0504_0302_0100, 0, 1, "preload2");
    store0(56'h13, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 3, 1, "byte_store");
    load0(56'h10, 2'd3, 1'b0, 64'h0706_0504_AB02_0100, "merge_dw");
    load0(56'h13, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, "ld_b_signed");
    load0(56'h13, 2'd0, 1'b1, 64'h0000_0000_0000_00AB, "ld_b_unsigned");
    load0(56'h12, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_AB02, "ld_h_signed");
    load0(56'h10, 2'd2, 1'b1, 64'h0000_0000_AB02_0100, "ld_w_unsigned");
    load0(56'h10, 2'd2, 1'b0, 64'hFFFF_FFFF_AB02_0100, "ld_w_signed");

    // write-once: held store writes once, retagged data writes again
    bus0.data_address = 56'h20;
    bus0.data_size = 2'd3;
    bus0.output_data = 64'h1122_3344_5566_7788;
    bus0.output_data_request = 1'b1;
    nw = 0;
    repeat (12) begin
      if (dut0.ram_we) nw++;
      tick(1);
    end
    check("wonce_complete", 64'(bus0.output_data_complete), 64'd1);
    check("wonce_writes", 64'(nw), 64'd1);
    bus0.output_data = 64'h8877_6655_4433_2211;
    #1;
    check("wonce_retag_drop", 64'(bus0.output_data_complete), 64'd0);
    nw = 0;
    repeat (12) begin
      if (dut0.ram_we) nw++;
      tick(1);
    end
    check("wonce2_writes", 64'(nw), 64'd1);
    bus0.output_data_request = 1'b0;
    tick(1);
    load0(56'h20, 2'd3, 1'b0, 64'h8877_6655_4433_2211, "wonce_readback");

    // boundary cases
    load0(56'h11, 2'd1, 1'b1, 64'd0, "mis_half");
    store0(56'h22, 2'd2, 64'h0000_0000_FFFF_FFFF, 1, 0, "mis_store");
    load0(56'h20, 2'd3, 1'b0, 64'h8877_6655_4433_2211, "mis_store_ram");
    store0(56'(MW*8), 2'd3, 64'hDEAD_BEEF_DEAD_BEEF, 1, 0, "oor_store");
    load0(56'h0, 2'd3, 1'b0, 64'h0000_0093_0000_0013, "oor_store_ram");
    load0(56'(MW*8), 2'd3, 1'b0, 64'd0, "oor_load");
    fetch0(56'(MW*8 + 4), 32'h0000_0013, "oor_fetch");

    // arbitration at W=2: data first, fetch chained directly after
    bus2.instruction_address = 56'h0;
    bus2.input_instruction_request = 1'b1;
    bus2.data_address = 56'h8;
    bus2.data_size = 2'd3;
    bus2.input_data_request = 1'b1;
    first_d = -1;
    first_i = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (first_d < 0 && bus2.input_data_valid) first_d = i;
      if (first_i < 0 && bus2.input_instruction_valid) first_i = i;
    end
    check("arb_load_edge", 64'(first_d), 64'd3);
    check("arb_fetch_edge", 64'(first_i), 64'd6);
    check("arb_load_held", 64'(bus2.input_data_valid), 64'd1);
    check("arb_fetch_held", 64'(bus2.input_instruction_valid), 64'd1);
    bus2.input_data_request = 1'b0;
    #1;
    check("arb_load_drop", 64'(bus2.input_data_valid), 64'd0);
    bus2.input_instruction_request = 1'b0;
    tick(1);

    // reset during BUSY_D of a W=3 store
    bus3.data_address = 56'h8;
    bus3.data_size = 2'd3;
    bus3.output_data = 64'h0123_4567_89AB_CDEF;
    bus3.output_data_request = 1'b1;
    k = 0;
    while (!bus3.output_data_complete && k < 20) begin
      tick(1);
      k++;
    end
    check("w3_store_complete", 64'(bus3.output_data_complete), 64'd1);
    bus3.output_data_request = 1'b0;
    tick(1);
    bus3.output_data = 64'hDEAD_DEAD_DEAD_DEAD;
    bus3.output_data_request = 1'b1;
    bad3 = 0;
    tick(2);
    rst3 = 1'b1;
    bus3.output_data_request = 1'b0;
    repeat (2) begin
      if (bus3.output_data_complete || dut3.ram_we) bad3++;
      tick(1);
    end
    rst3 = 1'b0;
    repeat (5) begin
      if (bus3.output_data_complete || dut3.ram_we) bad3++;
      tick(1);
    end
    check("rst_mid_no_complete", 64'(bad3), 64'd0);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    bus3.input_data_request = 1'b1;
    k = 0;
    while (!bus3.input_data_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("rst_mid_load_valid", 64'(bus3.input_data_valid), 64'd1);
    e = exp_q.pop_front();
    check("rst_mid_ram", bus3.input_data, e);
    bus3.input_data_request = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
